// File: rtl/morse_pkg.sv
// Shared constants for the Morse letter sender: FSM encodings, pattern ROM and lengths.
// Patterns are MSB-first and left-aligned so the LED always shows the top bit.
package morse_pkg;

  localparam int PAT_W = 12;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Entry n is letter n (0=A .. 7=H); listed H first because of packed ordering.
  localparam logic [7:0][PAT_W-1:0] PAT_ROM = {
    12'b1010_1010_0000,  // H
    12'b1110_1110_1000,  // G
    12'b1010_1110_1000,  // F
    12'b1000_0000_0000,  // E
    12'b1110_1010_0000,  // D
    12'b1110_1011_1010,  // C
    12'b1110_1010_1000,  // B
    12'b1011_1000_0000   // A
  };

  localparam logic [7:0][3:0] LEN_ROM = {
    4'd7, 4'd9, 4'd9, 4'd1, 4'd7, 4'd11, 4'd9, 4'd5
  };

  function automatic logic [PAT_W-1:0] pattern_of(input logic [2:0] letter);
    return PAT_ROM[letter];
  endfunction

  function automatic logic [3:0] length_of(input logic [2:0] letter);
    return LEN_ROM[letter];
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Loadable down-counter producing one tick every TICK_CYCLES clocks.
// tick is high while the count is zero; load or tick reloads the count.
module tick_divider #(
  parameter int TICK_CYCLES = 25000000
) (
  input  logic ClockIn,
  input  logic Reset,
  input  logic load,
  output logic tick
);

  localparam int DIV_W = $clog2(TICK_CYCLES);
  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(TICK_CYCLES - 1);

  logic [DIV_W-1:0] count_reg;

  assign tick = (count_reg == '0);

  // Reloading on tick means the count never wraps below zero.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      count_reg <= '0;
    end else if (load || tick) begin
      count_reg <= RELOAD;
    end else begin
      count_reg <= count_reg - DIV_W'(1);
    end
  end

endmodule

// File: rtl/morse_letter_sender.sv
// Sends one letter A..H as Morse code on an LED, one pattern bit per divider tick.
// The letter is latched when Start is accepted in IDLE; inputs are ignored while sending.
module morse_letter_sender
  import morse_pkg::*;
#(
  parameter int TICK_CYCLES = 25000000
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic [2:0] Letter,
  input  logic       Start,
  output logic       LedOut,
  output logic       Busy,
  output logic       Done
);

  logic [0:0]       state_reg;
  logic [PAT_W-1:0] shreg_reg;
  logic [PAT_W-1:0] shreg_shift;
  logic [3:0]       bitcnt_reg;
  logic             load;
  logic             tick;
  logic             sending;

  assign sending = (state_reg == ST_SEND);
  assign load    = (state_reg == ST_IDLE) && Start;

  tick_divider #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_divider (
    .ClockIn(ClockIn),
    .Reset  (Reset),
    .load   (load),
    .tick   (tick)
  );

  assign shreg_shift[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < PAT_W; gi++) begin : g_shift
      assign shreg_shift[gi] = shreg_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_reg  <= ST_IDLE;
      shreg_reg  <= '0;
      bitcnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (Start) begin
            state_reg  <= ST_SEND;
            shreg_reg  <= pattern_of(Letter);
            bitcnt_reg <= length_of(Letter);
          end
        end
        default: begin
          if (tick) begin
            if (bitcnt_reg > 4'd1) begin
              shreg_reg  <= shreg_shift;
              bitcnt_reg <= bitcnt_reg - 4'd1;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  // All outputs decode registered state only, so Reset clears them at once.
  assign LedOut = sending & shreg_reg[PAT_W-1];
  assign Busy   = sending;
  assign Done   = sending & tick & (bitcnt_reg <= 4'd1);

endmodule
